// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order reorder buffer sitting between dispatch and the retire
//   stage. One entry is allocated per cycle at the tail, one CDB broadcast per
//   cycle marks an entry complete, and the head entry is presented every cycle
//   as a flat ROB_IR_PACKET. A retiring taken branch squashes the whole buffer;
//   a retiring halt freezes retire and dispatch until reset.
//
//   Optional feature macro: ROB_STALL_CNT_EN
//     defined   -> adds output stall_full_cycles, a saturating count of cycles
//                  with dispatch_en && full (cleared only by reset_n).
//     undefined -> port and counter are absent.
//
// Ports
//   clock, reset_n            core clock / asynchronous active-low reset
//   dispatch_*                allocation request and entry payload
//   dispatch_idx              entry index handed to this cycle's dispatch (tail)
//   full, empty               occupancy flags decoded from the registered count
//   cdb_*                     completion broadcast for one entry
//   rob_ir_packet             head entry, MSB..LSB:
//                             {retire_en, retire_t, retire_t_old, dest_reg_idx,
//                              result, rs2_value, NPC, take_branch, wr_mem, halt}
//   flush                     a taken branch retires this cycle
//   stall_full_cycles         (ROB_STALL_CNT_EN only) full-stall cycle count
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter  int ROB_SZ      = 32,
    parameter  int PHYS_REG_SZ = 64,
    parameter  int XLEN        = 32,
    localparam int PRW         = $clog2(PHYS_REG_SZ),
    localparam int IW          = $clog2(ROB_SZ),
    localparam int PKT_W       = 1 + 2 * PRW + 5 + 3 * XLEN + 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             dispatch_en,
    input  logic [PRW-1:0]   dispatch_t,
    input  logic [PRW-1:0]   dispatch_t_old,
    input  logic [4:0]       dispatch_dest_idx,
    input  logic [XLEN-1:0]  dispatch_NPC,
    input  logic             dispatch_wr_mem,
    input  logic             dispatch_halt,
    output logic [IW-1:0]    dispatch_idx,
    output logic             full,
    output logic             empty,
    input  logic             cdb_en,
    input  logic [IW-1:0]    cdb_rob_idx,
    input  logic [XLEN-1:0]  cdb_result,
    input  logic [XLEN-1:0]  cdb_rs2_value,
    input  logic             cdb_take_branch,
    output logic [PKT_W-1:0] rob_ir_packet,
    output logic             flush
`ifdef ROB_STALL_CNT_EN
    ,
    output logic [31:0]      stall_full_cycles
`endif
);

    // Per-entry status and pointers
    logic [ROB_SZ-1:0] valid_q, valid_d;
    logic [ROB_SZ-1:0] complete_q, complete_d;
    logic [IW-1:0]     head_q, head_d;
    logic [IW-1:0]     tail_q, tail_d;
    logic [IW:0]       count_q, count_d;
    logic              halted_q, halted_d;

    // Per-entry payload (qualified by valid/complete, so no reset needed)
    logic [PRW-1:0]  ent_t_q      [ROB_SZ];
    logic [PRW-1:0]  ent_t_old_q  [ROB_SZ];
    logic [4:0]      ent_dest_q   [ROB_SZ];
    logic [XLEN-1:0] ent_npc_q    [ROB_SZ];
    logic            ent_wr_mem_q [ROB_SZ];
    logic            ent_halt_q   [ROB_SZ];
    logic [XLEN-1:0] ent_result_q [ROB_SZ];
    logic [XLEN-1:0] ent_rs2_q    [ROB_SZ];
    logic            ent_tb_q     [ROB_SZ];

    logic accept_s;
    logic retire_en_s;
    logic flush_s;
    logic cdb_hit_s;

    assign full         = (count_q == ROB_SZ[IW:0]);
    assign empty        = (count_q == {(IW + 1){1'b0}});
    assign dispatch_idx = tail_q;

    // Retire is a pure decode of registered state, so a CDB write to the head
    // only becomes retirable on the following cycle.
    assign retire_en_s = valid_q[head_q] & complete_q[head_q] & ~halted_q;
    assign flush_s     = retire_en_s & ent_tb_q[head_q];
    assign flush       = flush_s;
    // full is the registered flag: a same-cycle retire never frees the slot early.
    assign accept_s    = dispatch_en & ~full & ~flush_s & ~halted_q;
    assign cdb_hit_s   = cdb_en & valid_q[cdb_rob_idx];

    assign rob_ir_packet = {retire_en_s,
                            ent_t_q[head_q],
                            ent_t_old_q[head_q],
                            ent_dest_q[head_q],
                            ent_result_q[head_q],
                            ent_rs2_q[head_q],
                            ent_npc_q[head_q],
                            ent_tb_q[head_q],
                            ent_wr_mem_q[head_q],
                            ent_halt_q[head_q]};

    // Next-state for status bits, pointers, occupancy and the halt latch
    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        halted_d   = halted_q | (retire_en_s & ent_halt_q[head_q]);
        if (flush_s) begin
            // Squash discards this cycle's dispatch and CDB write as well.
            valid_d    = {ROB_SZ{1'b0}};
            complete_d = {ROB_SZ{1'b0}};
            head_d     = {IW{1'b0}};
            tail_d     = {IW{1'b0}};
            count_d    = {(IW + 1){1'b0}};
        end else begin
            if (retire_en_s) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + {{(IW - 1){1'b0}}, 1'b1};
            end else begin
                head_d = head_q;
            end
            if (cdb_hit_s) begin
                complete_d[cdb_rob_idx] = 1'b1;
            end else begin
                complete_d = complete_d;
            end
            // The tail slot is never valid here, so the CDB cannot collide with it.
            if (accept_s) begin
                valid_d[tail_q]    = 1'b1;
                complete_d[tail_q] = 1'b0;
                tail_d             = tail_q + {{(IW - 1){1'b0}}, 1'b1};
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + {{IW{1'b0}}, accept_s} - {{IW{1'b0}}, retire_en_s};
        end
    end

    // Status and pointer registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= {ROB_SZ{1'b0}};
            complete_q <= {ROB_SZ{1'b0}};
            head_q     <= {IW{1'b0}};
            tail_q     <= {IW{1'b0}};
            count_q    <= {(IW + 1){1'b0}};
            halted_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
        end
    end

    // Payload storage: dispatch fields at allocation, completion fields from the CDB
    always_ff @(posedge clock) begin
        if (accept_s) begin
            ent_t_q[tail_q]      <= dispatch_t;
            ent_t_old_q[tail_q]  <= dispatch_t_old;
            ent_dest_q[tail_q]   <= dispatch_dest_idx;
            ent_npc_q[tail_q]    <= dispatch_NPC;
            ent_wr_mem_q[tail_q] <= dispatch_wr_mem;
            ent_halt_q[tail_q]   <= dispatch_halt;
        end
        if (cdb_hit_s && !flush_s) begin
            ent_result_q[cdb_rob_idx] <= cdb_result;
            ent_rs2_q[cdb_rob_idx]    <= cdb_rs2_value;
            ent_tb_q[cdb_rob_idx]     <= cdb_take_branch;
        end
    end

`ifdef ROB_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where dispatch is blocked by a full buffer
    always_comb begin
        stall_d = stall_q;
        if (dispatch_en && full && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register; flush deliberately leaves it alone
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_full_cycles = stall_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Scoreboard bench: each accepted dispatch pushes an expected retire record,
//   CDB stimulus fills in its completion fields, and every cycle the head of
//   the queue is compared with rob_ir_packet together with full/empty/flush
//   and dispatch_idx derived from the bench's own occupancy model.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

    localparam int ROB_SZ = 32;

    logic        clock;
    logic        reset_n;
    logic        dispatch_en;
    logic [5:0]  dispatch_t;
    logic [5:0]  dispatch_t_old;
    logic [4:0]  dispatch_dest_idx;
    logic [31:0] dispatch_NPC;
    logic        dispatch_wr_mem;
    logic        dispatch_halt;
    logic [4:0]  dispatch_idx;
    logic        full;
    logic        empty;
    logic        cdb_en;
    logic [4:0]  cdb_rob_idx;
    logic [31:0] cdb_result;
    logic [31:0] cdb_rs2_value;
    logic        cdb_take_branch;
    logic [116:0] rob_ir_packet;
    logic        flush;
`ifdef ROB_STALL_CNT_EN
    logic [31:0] stall_full_cycles;
`endif

    logic        r_en;
    logic [5:0]  r_t;
    logic [5:0]  r_told;
    logic [4:0]  r_dest;
    logic [31:0] r_res;
    logic [31:0] r_rs2;
    logic [31:0] r_npc;
    logic        r_tb;
    logic        r_wr;
    logic        r_halt;

    assign {r_en, r_t, r_told, r_dest, r_res, r_rs2, r_npc, r_tb, r_wr, r_halt} = rob_ir_packet;

    reorder_buffer #(.ROB_SZ(32), .PHYS_REG_SZ(64), .XLEN(32)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .dispatch_en       (dispatch_en),
        .dispatch_t        (dispatch_t),
        .dispatch_t_old    (dispatch_t_old),
        .dispatch_dest_idx (dispatch_dest_idx),
        .dispatch_NPC      (dispatch_NPC),
        .dispatch_wr_mem   (dispatch_wr_mem),
        .dispatch_halt     (dispatch_halt),
        .dispatch_idx      (dispatch_idx),
        .full              (full),
        .empty             (empty),
        .cdb_en            (cdb_en),
        .cdb_rob_idx       (cdb_rob_idx),
        .cdb_result        (cdb_result),
        .cdb_rs2_value     (cdb_rs2_value),
        .cdb_take_branch   (cdb_take_branch),
        .rob_ir_packet     (rob_ir_packet),
        .flush             (flush)
`ifdef ROB_STALL_CNT_EN
        ,
        .stall_full_cycles (stall_full_cycles)
`endif
    );

    typedef struct {
        logic [4:0]  idx;
        logic [5:0]  t;
        logic [5:0]  told;
        logic [4:0]  dest;
        logic [31:0] npc;
        logic [31:0] res;
        logic [31:0] rs2;
        logic        wr;
        logic        halt;
        logic        tb;
        logic        done;
    } ent_t;

    ent_t        sb_q[$];
    int          count_m;
    logic [4:0]  tail_m;
    logic        halted_m;
    int          stall_m;
    int          seq;
    int          checks;
    int          errors;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it when observed and expected differ
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_disp(input logic halt);
        dispatch_en       = 1'b1;
        dispatch_t        = seq[5:0];
        dispatch_t_old    = 6'(seq + 7);
        dispatch_dest_idx = 5'(seq * 3);
        dispatch_NPC      = 32'h0000_1000 + 32'(seq * 4);
        dispatch_wr_mem   = seq[0];
        dispatch_halt     = halt;
        seq++;
    endtask

    task automatic drive_cdb(input logic [4:0] idx, input logic tb, input logic [31:0] res);
        cdb_en          = 1'b1;
        cdb_rob_idx     = idx;
        cdb_result      = res;
        cdb_rs2_value   = ~res;
        cdb_take_branch = tb;
    endtask

    // Sample outputs mid-low-phase, check against the model, then advance one edge
    task automatic cycle();
        logic re;
        logic fl;
        logic acc;
        #1;
        re = (sb_q.size() > 0) && sb_q[0].done && !halted_m;
        fl = re && sb_q[0].tb;
        chk("retire_en", r_en, re);
        chk("flush", flush, fl);
        chk("full", full, count_m == ROB_SZ);
        chk("empty", empty, count_m == 0);
        chk("dispatch_idx", dispatch_idx, tail_m);
        if (re) begin
            chk("retire_t", r_t, sb_q[0].t);
            chk("retire_t_old", r_told, sb_q[0].told);
            chk("dest_reg_idx", r_dest, sb_q[0].dest);
            chk("result", r_res, sb_q[0].res);
            chk("rs2_value", r_rs2, sb_q[0].rs2);
            chk("NPC", r_npc, sb_q[0].npc);
            chk("wr_mem", r_wr, sb_q[0].wr);
            chk("halt", r_halt, sb_q[0].halt);
        end
        acc = dispatch_en && (count_m < ROB_SZ) && !fl && !halted_m;
        if (dispatch_en && count_m == ROB_SZ) stall_m++;
        if (fl) begin
            sb_q.delete();
            count_m = 0;
            tail_m  = 5'd0;
        end else begin
            if (re) begin
                if (sb_q[0].halt) halted_m = 1'b1;
                void'(sb_q.pop_front());
                count_m--;
            end
            if (cdb_en) begin
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (sb_q[i].idx == cdb_rob_idx) begin
                        sb_q[i].done = 1'b1;
                        sb_q[i].res  = cdb_result;
                        sb_q[i].rs2  = cdb_rs2_value;
                        sb_q[i].tb   = cdb_take_branch;
                    end
                end
            end
            if (acc) begin
                ent_t e;
                e.idx  = tail_m;
                e.t    = dispatch_t;
                e.told = dispatch_t_old;
                e.dest = dispatch_dest_idx;
                e.npc  = dispatch_NPC;
                e.wr   = dispatch_wr_mem;
                e.halt = dispatch_halt;
                e.res  = 32'd0;
                e.rs2  = 32'd0;
                e.tb   = 1'b0;
                e.done = 1'b0;
                sb_q.push_back(e);
                tail_m = tail_m + 5'd1;
                count_m++;
            end
        end
        @(negedge clock);
        dispatch_en     = 1'b0;
        dispatch_halt   = 1'b0;
        cdb_en          = 1'b0;
        cdb_take_branch = 1'b0;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_retire_en", r_en, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_dispatch_idx", dispatch_idx, 5'd0);
        sb_q.delete();
        count_m  = 0;
        tail_m   = 5'd0;
        halted_m = 1'b0;
        stall_m  = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; seq = 1;
        count_m = 0; tail_m = 5'd0; halted_m = 1'b0; stall_m = 0;
        reset_n = 1'b0;
        dispatch_en = 1'b0; dispatch_t = 6'd0; dispatch_t_old = 6'd0;
        dispatch_dest_idx = 5'd0; dispatch_NPC = 32'd0; dispatch_wr_mem = 1'b0;
        dispatch_halt = 1'b0; cdb_en = 1'b0; cdb_rob_idx = 5'd0;
        cdb_result = 32'd0; cdb_rs2_value = 32'd0; cdb_take_branch = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cycle();

        // T1: five valid entries, head retirable, then async reset
        for (int i = 0; i < 5; i++) begin drive_disp(1'b0); cycle(); end
        drive_cdb(5'd0, 1'b0, 32'hAAAA_0000);
        cycle();
        chk("t1_pre_retire", r_en, 1'b1);
        async_reset();
        cycle();

        // T2: complete out of order, retire strictly in order
        for (int i = 0; i < 3; i++) begin drive_disp(1'b0); cycle(); end
        drive_cdb(5'd2, 1'b0, 32'h2222_2222); cycle();
        drive_cdb(5'd1, 1'b0, 32'h1111_1111); cycle();
        cycle();
        drive_cdb(5'd0, 1'b0, 32'h0000_0BAD); cycle();
        for (int i = 0; i < 4; i++) cycle();

        // T3: fill to full, drop the 33rd, retire one and wrap the tail
        async_reset();
        for (int i = 0; i < ROB_SZ; i++) begin drive_disp(1'b0); cycle(); end
        drive_disp(1'b0); cycle();
        drive_cdb(5'd0, 1'b0, 32'h3333_0000); cycle();
        drive_disp(1'b0); cycle();
        chk("t3_wrap_idx", dispatch_idx, 5'd0);
        drive_disp(1'b0); cycle();
        chk("t3_full_again", full, 1'b1);
        cycle();

        // T4: taken branch at head squashes everything, flush-cycle dispatch lost
        async_reset();
        for (int i = 0; i < 6; i++) begin drive_disp(1'b0); cycle(); end
        drive_cdb(5'd0, 1'b1, 32'h0000_0100); cycle();
        chk("t4_flush", flush, 1'b1);
        chk("t4_result", r_res, 32'h0000_0100);
        drive_disp(1'b0);
        drive_cdb(5'd3, 1'b0, 32'h4444_4444);
        cycle();
        chk("t4_empty_after", empty, 1'b1);
        cycle();

        // T5: halt retires once, then retire and dispatch are frozen
        drive_disp(1'b1); cycle();
        drive_disp(1'b0); cycle();
        drive_cdb(5'd1, 1'b0, 32'h5555_0001); cycle();
        drive_cdb(5'd0, 1'b0, 32'h5555_0000); cycle();
        chk("t5_halt_retire", r_halt, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin drive_disp(1'b0); cycle(); end
        chk("t5_frozen_idx", dispatch_idx, 5'd2);

`ifdef ROB_STALL_CNT_EN
        // T6: ten dispatch attempts against a full buffer
        async_reset();
        for (int i = 0; i < ROB_SZ; i++) begin drive_disp(1'b0); cycle(); end
        for (int i = 0; i < 10; i++) begin drive_disp(1'b0); cycle(); end
        chk("t6_stall_cnt", stall_full_cycles, 32'd10);
        chk("t6_stall_model", stall_full_cycles, 32'(stall_m));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
